// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame width and the
// baud divisor function used by both the receiver and the transmitter.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    STOP       = 3'd3,
    BREAK_WAIT = 3'd4
  } rx_state_t;

  // Clocks per oversample tick, rounded to the nearest integer.
  function automatic int uart_divisor(input int clk_freq_hz,
                                      input int baud_rate,
                                      input int oversample);
    longint num;
    longint den;
    den = longint'(baud_rate) * longint'(oversample);
    num = longint'(clk_freq_hz) + den / 2;
    return int'(num / den);
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Free-running clock divider producing a one-cycle tick every DIVISOR clocks,
// with a synchronous clear that restarts the count from zero.
module uart_tick_gen #(
  parameter int DIVISOR = 11
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with 16x oversampling, a 2-FF input synchronizer and a
// valid/ready holding register with frame and overrun error pulses.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 20000000,
  parameter int BAUD_RATE   = 115200,
  parameter int OVERSAMPLE  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_busy,
  output logic                 frame_error,
  output logic                 overrun_error
);

  localparam int DIVISOR = uart_divisor(CLK_FREQ_HZ, BAUD_RATE, OVERSAMPLE);
  localparam int TW      = $clog2(OVERSAMPLE);
  localparam int BW      = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic rx_meta;
  logic rx_s;

  rx_state_t state;
  rx_state_t state_next;
  logic [TW-1:0] tick_cnt;
  logic [TW-1:0] tick_cnt_next;
  logic [BW-1:0] bit_idx;
  logic [BW-1:0] bit_idx_next;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] shift_next;

  logic tick;
  logic div_clear;
  logic stop_sample;
  logic deliver;
  logic frame_bad;

  // The line idles high, so the synchronizer resets to 1 to avoid a false start.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
    end
  end

  uart_tick_gen #(
    .DIVISOR(DIVISOR)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .clear(div_clear),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      state    <= state_next;
      tick_cnt <= tick_cnt_next;
      bit_idx  <= bit_idx_next;
      shift    <= shift_next;
    end
  end

  always_comb begin
    state_next    = state;
    tick_cnt_next = tick_cnt;
    bit_idx_next  = bit_idx;
    shift_next    = shift;
    div_clear     = 1'b0;
    stop_sample   = 1'b0;

    case (state)
      IDLE: begin
        tick_cnt_next = '0;
        if (!rx_s) begin
          state_next = START;
          div_clear  = 1'b1;
        end
      end

      // A start bit still low at mid-bit is genuine; otherwise it was a glitch.
      START: begin
        if (tick) begin
          if (tick_cnt == TICK_HALF) begin
            tick_cnt_next = '0;
            if (!rx_s) begin
              state_next   = DATA;
              bit_idx_next = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            tick_cnt_next = tick_cnt + 1'b1;
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt_next       = '0;
            shift_next[bit_idx] = rx_s;
            if (bit_idx == BIT_LAST) begin
              state_next = STOP;
            end else begin
              bit_idx_next = bit_idx + 1'b1;
            end
          end else begin
            tick_cnt_next = tick_cnt + 1'b1;
          end
        end
      end

      STOP: begin
        if (tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt_next = '0;
            stop_sample   = 1'b1;
            state_next    = rx_s ? IDLE : BREAK_WAIT;
          end else begin
            tick_cnt_next = tick_cnt + 1'b1;
          end
        end
      end

      // A held-low line must return high before another start can be seen.
      BREAK_WAIT: begin
        if (rx_s) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign deliver   = stop_sample && rx_s;
  assign frame_bad = stop_sample && !rx_s;
  assign rx_busy   = (state != IDLE);

  // Holding register: a full, unaccepted register keeps its byte and the new one is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      frame_error   <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      frame_error   <= frame_bad;
      overrun_error <= 1'b0;
      if (deliver) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift;
          rx_valid <= 1'b1;
        end else begin
          overrun_error <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: frames are driven bit by bit, expected
// bytes and error counts come from a frame-level model, a monitor checks accepts.
module tb_uart_receiver;

  localparam int BIT_CLKS = 176;

  logic       clk = 1'b0;
  logic       reset;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_busy;
  logic       frame_error;
  logic       overrun_error;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_fe   = 0;
  int exp_ov   = 0;
  int fe_seen  = 0;
  int ov_seen  = 0;
  logic [7:0] exp_q[$];

  uart_receiver #(
    .CLK_FREQ_HZ(20000000),
    .BAUD_RATE  (115200),
    .OVERSAMPLE (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .uart_rx      (uart_rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_busy      (rx_busy),
    .frame_error  (frame_error),
    .overrun_error(overrun_error)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic tickClk(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Model: a good frame lands in the holding register unless it is still full and not being read.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input logic check_busy);
    if (!stop_bit) exp_fe++;
    else if (exp_q.size() != 0 && !rx_ready) exp_ov++;
    else exp_q.push_back(data);
    for (int b = 0; b < 10; b++) begin
      if (b == 0) uart_rx = 1'b0;
      else if (b == 9) uart_rx = stop_bit;
      else uart_rx = data[b-1];
      tickClk(80);
      if (check_busy) checkOutput($sformatf("busy_bit%0d", b), rx_busy, 1);
      tickClk(BIT_CLKS - 80);
    end
  endtask

  task automatic endScenario(input string name);
    int i;
    for (i = 0; i < 3000 && exp_q.size() != 0; i++) tickClk(1);
    checkOutput({name, "_drained"}, exp_q.size(), 0);
    checkOutput({name, "_frame_errors"}, fe_seen, exp_fe);
    checkOutput({name, "_overruns"}, ov_seen, exp_ov);
  endtask

  initial begin : monitor
    logic [7:0] exp_byte;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (frame_error) fe_seen++;
        if (overrun_error) ov_seen++;
        if (frame_error || overrun_error)
          checkOutput("errors_exclusive", int'(frame_error && overrun_error), 0);
        if (rx_valid && rx_ready) begin
          checkOutput("accept_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            exp_byte = exp_q.pop_front();
            checkOutput("rx_data", rx_data, exp_byte);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #3ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    logic [7:0] rnd;
    reset    = 1'b1;
    uart_rx  = 1'b1;
    rx_ready = 1'b1;
    tickClk(5);
    checkOutput("reset_rx_data", rx_data, 0);
    checkOutput("reset_rx_valid", rx_valid, 0);
    checkOutput("reset_rx_busy", rx_busy, 0);
    checkOutput("reset_frame_error", frame_error, 0);
    checkOutput("reset_overrun", overrun_error, 0);
    reset = 1'b0;
    tickClk(20);

    $display("[TB] single 0x55 frame");
    applyStimulus(8'h55, 1'b1, 1'b1);
    endScenario("single");

    $display("[TB] back-to-back 0xA3, 0x0F");
    applyStimulus(8'hA3, 1'b1, 1'b0);
    applyStimulus(8'h0F, 1'b1, 1'b0);
    endScenario("b2b");

    $display("[TB] start glitch");
    uart_rx = 1'b0;
    tickClk(3);
    uart_rx = 1'b1;
    tickClk(20);
    checkOutput("glitch_busy", rx_busy, 1);
    tickClk(200);
    checkOutput("glitch_idle", rx_busy, 0);
    checkOutput("glitch_valid", rx_valid, 0);
    endScenario("glitch");

    $display("[TB] framing error and break");
    applyStimulus(8'hC4, 1'b0, 1'b0);
    tickClk(2000);
    checkOutput("break_valid", rx_valid, 0);
    uart_rx = 1'b1;
    tickClk(200);
    endScenario("break");
    applyStimulus(8'h12, 1'b1, 1'b0);
    endScenario("after_break");

    $display("[TB] overrun with rx_ready low");
    rx_ready = 1'b0;
    applyStimulus(8'h11, 1'b1, 1'b0);
    applyStimulus(8'h22, 1'b1, 1'b0);
    tickClk(20);
    checkOutput("overrun_valid", rx_valid, 1);
    checkOutput("overrun_data", rx_data, 8'h11);
    checkOutput("overrun_count", ov_seen, exp_ov);
    rx_ready = 1'b1;
    tickClk(1);
    rx_ready = 1'b0;
    tickClk(1);
    checkOutput("overrun_valid_drop", rx_valid, 0);
    rx_ready = 1'b1;
    endScenario("overrun");

    $display("[TB] reset during bit 4 of 0xFF");
    uart_rx = 1'b0;
    tickClk(BIT_CLKS);
    uart_rx = 1'b1;
    tickClk(4 * BIT_CLKS + BIT_CLKS / 2);
    reset = 1'b1;
    tickClk(2);
    reset = 1'b0;
    tickClk(1);
    checkOutput("midreset_rx_data", rx_data, 0);
    checkOutput("midreset_rx_valid", rx_valid, 0);
    checkOutput("midreset_rx_busy", rx_busy, 0);
    tickClk(2 * BIT_CLKS);
    endScenario("midreset");
    applyStimulus(8'h3C, 1'b1, 1'b0);
    endScenario("after_reset");

    $display("[TB] random frames");
    for (int i = 0; i < 6; i++) begin
      rnd = 8'($urandom_range(0, 255));
      tickClk($urandom_range(0, 300));
      applyStimulus(rnd, 1'b1, 1'b0);
    end
    endScenario("random");

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
